// File: rtl/accum64_stream_if.sv
// Stream bus for accum64_stream: operand beat channel in, result channel out.
// master = producer of operands / consumer of results, slave = the accumulator.
interface accum64_stream_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             in_sub;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_carry;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_sub, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_carry, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_sub, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_carry, out_ovf
  );
endinterface

// File: rtl/accum64_stream.sv
// accum64_stream: folds a valid/ready stream of 64-bit operands into a running
// total through a 64-bit ripple adder built from four chained 16-bit slices.
// The beat marked last moves the block to HOLD, where total, operand count and
// sticky carry/overflow flags are presented until the consumer takes them.
// Optional build macro: ACCUM64_OVF_EN enables sticky signed-overflow detection;
// without it out_ovf is tied to 0.
module accum64_stream #(
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  accum64_stream_if.slave bus
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [63:0]      acc_reg, acc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             carry_reg, carry_next;

  // A beat is taken only while accumulating; in_ready is a pure state decode.
  logic accept;
  assign accept = (state_reg == ACCUM) && bus.in_valid;

  // Adder operands: subtraction is A + ~B + 1, the +1 riding in on c_in.
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic [63:0] add_sum;
  logic [4:0]  slice_c;
  logic        add_cout;

  assign add_a      = acc_reg;
  assign add_b      = bus.in_sub ? ~bus.in_data : bus.in_data;
  assign slice_c[0] = bus.in_sub;
  assign add_cout   = slice_c[4];

  // Four 16-bit slices chained through slice_c, matching the upstream adder.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
      assign {slice_c[gi+1], add_sum[16*gi +: 16]} =
        {1'b0, add_a[16*gi +: 16]} + {1'b0, add_b[16*gi +: 16]} + {16'b0, slice_c[gi]};
    end
  endgenerate

  // Next-state and datapath update: accumulate in ACCUM, clear on result handshake.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    carry_next = carry_reg;
    case (state_reg)
      ACCUM: begin
        if (accept) begin
          acc_next   = add_sum;
          carry_next = carry_reg | add_cout;
          if (count_reg != {CNT_W{1'b1}}) begin
            count_next = count_reg + CNT_W'(1);
          end
          if (bus.in_last) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          acc_next   = '0;
          count_next = '0;
          carry_next = 1'b0;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // State and accumulator registers; reset discards any partial total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      count_reg <= '0;
      carry_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      carry_reg <= carry_next;
    end
  end

`ifdef ACCUM64_OVF_EN
  logic ovf_reg, ovf_next;
  logic beat_ovf;

  // Signed overflow: operands agree in sign but the sum does not.
  assign beat_ovf = (add_a[63] == add_b[63]) && (add_sum[63] != add_a[63]);

  // Sticky overflow follows the same accept/clear timing as the carry flag.
  always_comb begin
    ovf_next = ovf_reg;
    if (accept) begin
      ovf_next = ovf_reg | beat_ovf;
    end else if ((state_reg == HOLD) && bus.out_ready) begin
      ovf_next = 1'b0;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_next;
    end
  end

  assign bus.out_ovf = ovf_reg;
`else
  assign bus.out_ovf = 1'b0;
`endif

  // Outputs are straight register decodes; nothing from in_* reaches out_*.
  assign bus.in_ready  = (state_reg == ACCUM);
  assign bus.out_valid = (state_reg == HOLD);
  assign bus.out_sum   = acc_reg;
  assign bus.out_count = count_reg;
  assign bus.out_carry = carry_reg;

endmodule

// File: tb/tb_accum64_stream.sv
// Bench for accum64_stream: directed cases plus randomized accumulations,
// checked against an arithmetic model of the running total and flags.
module tb_accum64_stream;
  localparam int CNT_W = 8;
  localparam int BOUND = 20;

  logic clk;
  logic rst_n;

  accum64_stream_if #(.CNT_W(CNT_W)) bus ();

  accum64_stream #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int acc_no = 0;

  // Reference model state for the accumulation in progress.
  logic [63:0] m_sum;
  int          m_count;
  logic        m_carry;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_sum = '0; m_count = 0; m_carry = 1'b0; m_ovf = 1'b0;
  endtask

  // Plain arithmetic view: total +/- operand, carry = no unsigned wrap/borrow,
  // overflow = true signed result outside 64-bit range.
  task automatic model_beat(input logic [63:0] d, input logic s);
    logic signed [64:0] r;
    logic [64:0]        u;
    if (s) begin
      r = $signed({m_sum[63], m_sum}) - $signed({d[63], d});
      m_carry = m_carry | (m_sum >= d);
      m_sum = m_sum - d;
    end else begin
      r = $signed({m_sum[63], m_sum}) + $signed({d[63], d});
      u = {1'b0, m_sum} + {1'b0, d};
      m_carry = m_carry | u[64];
      m_sum = u[63:0];
    end
`ifdef ACCUM64_OVF_EN
    m_ovf = m_ovf | (r[64] != r[63]);
`else
    m_ovf = m_ovf | (r[64] & 1'b0);
`endif
    if (m_count < (1 << CNT_W) - 1) m_count++;
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [63:0] d, input logic s, input logic l);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sub = s; bus.in_last = l;
    while (bus.in_ready !== 1'b1 && n < BOUND) begin
      @(negedge clk); n++;
    end
    if (n >= BOUND) begin
      chk("in_ready_timeout", 64'(n), 64'(0));
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_beat(d, s);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Waits for a result, checks it against the model, holds a random number of
  // cycles, then completes the handshake and checks the return to ACCUM.
  task automatic get_result(output logic [63:0] o_sum, output logic [CNT_W-1:0] o_cnt,
                            output logic o_carry, output logic o_ovf);
    int n = 0;
    int w;
    while (bus.out_valid !== 1'b1 && n < BOUND) begin
      @(negedge clk); n++;
    end
    chk("out_valid", 64'(bus.out_valid), 64'(1));
    chk("latency", 64'(n), 64'(0));
    o_sum = bus.out_sum; o_cnt = bus.out_count; o_carry = bus.out_carry; o_ovf = bus.out_ovf;
    chk("sum", o_sum, m_sum);
    chk("count", 64'(o_cnt), 64'(m_count));
    chk("carry", 64'(o_carry), 64'(m_carry));
    chk("ovf", 64'(o_ovf), 64'(m_ovf));
    chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
    w = $urandom_range(0, 2);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      chk("hold_sum", bus.out_sum, m_sum);
      chk("hold_valid", 64'(bus.out_valid), 64'(1));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_in_ready", 64'(bus.in_ready), 64'(1));
    chk("post_out_valid", 64'(bus.out_valid), 64'(0));
    chk("post_sum_clear", bus.out_sum, 64'(0));
    chk("post_count_clear", 64'(bus.out_count), 64'(0));
    $display("acc %0d: sum=%h count=%0d carry=%0d ovf=%0d", acc_no, o_sum, o_cnt, o_carry, o_ovf);
    acc_no++;
    model_clear();
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 64'($urandom_range(0, 1000));
      1:       return {$urandom, $urandom};
      2:       return ($urandom_range(0, 1) != 0) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0]      r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_ovf;
    logic             exp_ovf;
    int               len;

`ifdef ACCUM64_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sub = 1'b0; bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_sum", bus.out_sum, 64'(0));
    chk("rst_count", 64'(bus.out_count), 64'(0));
    chk("rst_carry", 64'(bus.out_carry), 64'(0));
    chk("rst_ovf", 64'(bus.out_ovf), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 5 + 7
    send_beat(64'h5, 1'b0, 1'b0);
    send_beat(64'h7, 1'b0, 1'b1);
    get_result(r_sum, r_cnt, r_carry, r_ovf);
    chk("t1_sum", r_sum, 64'hC);
    chk("t1_count", 64'(r_cnt), 64'(2));
    chk("t1_carry", 64'(r_carry), 64'(0));

    // all-ones + 2 wraps with carry
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    send_beat(64'h2, 1'b0, 1'b1);
    get_result(r_sum, r_cnt, r_carry, r_ovf);
    chk("t2_sum", r_sum, 64'h1);
    chk("t2_carry", 64'(r_carry), 64'(1));
    chk("t2_ovf", 64'(r_ovf), 64'(0));

    // max positive + 1 overflows signed
    send_beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    send_beat(64'h1, 1'b0, 1'b1);
    get_result(r_sum, r_cnt, r_carry, r_ovf);
    chk("t3_sum", r_sum, 64'h8000_0000_0000_0000);
    chk("t3_ovf", 64'(r_ovf), 64'(exp_ovf));

    // 0x10 - 3 with a long stall in HOLD and a pending upstream beat
    send_beat(64'h10, 1'b0, 1'b0);
    send_beat(64'h3, 1'b1, 1'b1);
    bus.in_valid = 1'b1; bus.in_data = 64'h55; bus.in_sub = 1'b0; bus.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_sum", bus.out_sum, 64'hD);
      chk("stall_count", 64'(bus.out_count), 64'(2));
      chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
      chk("stall_valid", 64'(bus.out_valid), 64'(1));
    end
    get_result(r_sum, r_cnt, r_carry, r_ovf);
    chk("t4_sum", r_sum, 64'hD);
    chk("t4_carry", 64'(r_carry), 64'(1));
    send_beat(64'h55, 1'b0, 1'b1);
    get_result(r_sum, r_cnt, r_carry, r_ovf);
    chk("t4b_sum", r_sum, 64'h55);
    chk("t4b_count", 64'(r_cnt), 64'(1));

    // 300 back-to-back increments: counter saturates
    for (int i = 0; i < 300; i++) send_beat(64'h1, 1'b0, (i == 299));
    get_result(r_sum, r_cnt, r_carry, r_ovf);
    chk("t5_sum", r_sum, 64'd300);
    chk("t5_count", 64'(r_cnt), 64'(255));

    // reset mid-accumulation
    send_beat(64'h11, 1'b0, 1'b0);
    send_beat(64'h22, 1'b0, 1'b0);
    send_beat(64'h33, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_sum", bus.out_sum, 64'(0));
    chk("mid_rst_count", 64'(bus.out_count), 64'(0));
    chk("mid_rst_carry", 64'(bus.out_carry), 64'(0));
    chk("mid_rst_ovf", 64'(bus.out_ovf), 64'(0));
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(64'h9, 1'b0, 1'b1);
    get_result(r_sum, r_cnt, r_carry, r_ovf);
    chk("t6_sum", r_sum, 64'h9);
    chk("t6_count", 64'(r_cnt), 64'(1));

    // randomized accumulations, with occasional idle gaps between beats
    for (int a = 0; a < 25; a++) begin
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send_beat(rand_operand(), 1'($urandom_range(0, 1)), (b == len - 1));
      end
      get_result(r_sum, r_cnt, r_carry, r_ovf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
